// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
//  Shared encodings for the read arbiter: FSM state codes, OWNER codes and the
//  bus widths used by the bridge read port.
// ----------------------------------------------------------------------------
package mem_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_RESP = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } owner_t;

   // Map the arbiter's pick (1 = I wins, 0 = D wins) onto an OWNER code.
   function automatic owner_t owner_code(input logic pick_i);
      if (pick_i) begin
         return OWN_I;
      end else begin
         return OWN_D;
      end
   endfunction

endpackage

// File: rtl/arb_pick2.sv
// ----------------------------------------------------------------------------
// arb_pick2
//  Two-way winner selection between fetch (I) and load (D), with the history
//  registers it needs: last_grant for round-robin and wait_cnt for the
//  fixed-priority starvation guard.
// Ports
//  CLK, RST     clock, synchronous active-high reset
//  i_req_i      fetch request
//  d_req_i      load request
//  grant_i      a grant is taken this cycle (history registers update)
//  i_owner_i    I currently owns the bridge (stops wait_cnt counting)
//  pick_i_o     1 = I wins, 0 = D wins (meaningful only when a REQ is high)
// ----------------------------------------------------------------------------
module arb_pick2
   import mem_pkg::*;
#(
   parameter int ARB_MODE = 0,
   parameter int MAX_WAIT = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_req_i,
   input  logic d_req_i,
   input  logic grant_i,
   input  logic i_owner_i,
   output logic pick_i_o
);

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic       last_was_d_q;
   logic       last_was_d_d;
   logic [7:0] wait_cnt_q;
   logic [7:0] wait_cnt_d;
   logic       pick_i_s;

   // Winner selection: a lone request always wins; ties go by mode.
   always_comb begin
      pick_i_s = 1'b0;
      if (i_req_i && !d_req_i) begin
         pick_i_s = 1'b1;
      end else if (!i_req_i && d_req_i) begin
         pick_i_s = 1'b0;
      end else if (i_req_i && d_req_i) begin
         if (ARB_MODE == 0) begin
            // Alternate: I wins if D had the previous grant.
            pick_i_s = last_was_d_q;
         end else begin
            // D has priority until I has waited MAX_WAIT cycles.
            pick_i_s = (wait_cnt_q == MAX_WAIT_C);
         end
      end else begin
         pick_i_s = 1'b0;
      end
   end

   // Next-state for the grant history and the I starvation counter.
   always_comb begin
      last_was_d_d = last_was_d_q;
      wait_cnt_d   = wait_cnt_q;
      if (grant_i) begin
         last_was_d_d = ~pick_i_s;
      end else begin
         last_was_d_d = last_was_d_q;
      end
      if (grant_i && pick_i_s) begin
         wait_cnt_d = 8'd0;
      end else if (i_req_i && !i_owner_i && (wait_cnt_q < MAX_WAIT_C)) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // History registers; reset leaves D as last grant so I wins the first tie.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_was_d_q <= 1'b1;
         wait_cnt_q   <= 8'd0;
      end else begin
         last_was_d_q <= last_was_d_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign pick_i_o = pick_i_s;

endmodule

// File: rtl/axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// axi_read_arbiter
//  Shares the bridge's single read port between instruction fetch (I) and
//  data load (D). One read outstanding at a time: IDLE -> BUSY -> RESP.
// Ports
//  CLK, RST                 clock, synchronous active-high reset
//  I_REQ/I_ADDR             fetch request, address sampled at grant
//  I_ACK/I_RDATA            fetch one-cycle ack and held read data
//  D_REQ/D_ADDR             load request, address sampled at grant
//  D_ACK/D_RDATA            load one-cycle ack and held read data
//  DN_RDEN/DN_RADDR         read request to the bridge, held until DN_RVALID
//  DN_RVALID/DN_RDATA       bridge response (only honoured in BUSY)
//  OWNER                    current grant: 00 none, 01 I, 10 D
// ----------------------------------------------------------------------------
module axi_read_arbiter
   import mem_pkg::*;
#(
   parameter int ARB_MODE = 0,
   parameter int MAX_WAIT = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_REQ,
   input  logic [ADDR_W-1:0] I_ADDR,
   output logic              I_ACK,
   output logic [DATA_W-1:0] I_RDATA,
   input  logic              D_REQ,
   input  logic [ADDR_W-1:0] D_ADDR,
   output logic              D_ACK,
   output logic [DATA_W-1:0] D_RDATA,
   output logic              DN_RDEN,
   output logic [ADDR_W-1:0] DN_RADDR,
   input  logic              DN_RVALID,
   input  logic [DATA_W-1:0] DN_RDATA,
   output logic [1:0]        OWNER
);

   state_t            state_q;
   owner_t            owner_q;
   logic              rden_q;
   logic [ADDR_W-1:0] raddr_q;
   logic              i_ack_q;
   logic              d_ack_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic              grant_s;
   logic              pick_i_s;
   logic              i_owner_s;
   logic [ADDR_W-1:0] sel_addr_s;

   assign grant_s   = (state_q == S_IDLE) && (I_REQ || D_REQ);
   assign i_owner_s = (owner_q == OWN_I);

   arb_pick2 #(
      .ARB_MODE (ARB_MODE),
      .MAX_WAIT (MAX_WAIT)
   ) u_pick (
      .CLK       (CLK),
      .RST       (RST),
      .i_req_i   (I_REQ),
      .d_req_i   (D_REQ),
      .grant_i   (grant_s),
      .i_owner_i (i_owner_s),
      .pick_i_o  (pick_i_s)
   );

   // Address of the winning requester, captured only at grant.
   always_comb begin
      sel_addr_s = D_ADDR;
      if (pick_i_s) begin
         sel_addr_s = I_ADDR;
      end else begin
         sel_addr_s = D_ADDR;
      end
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_NONE;
         rden_q    <= 1'b0;
         raddr_q   <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // DN_RVALID here is stale (e.g. from before a reset): dropped.
               if (I_REQ || D_REQ) begin
                  owner_q <= owner_code(pick_i_s);
                  raddr_q <= sel_addr_s;
                  rden_q  <= 1'b1;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (DN_RVALID) begin
                  // Only the owner's data register is ever written.
                  if (owner_q == OWN_I) begin
                     i_rdata_q <= DN_RDATA;
                     i_ack_q   <= 1'b1;
                  end else begin
                     d_rdata_q <= DN_RDATA;
                     d_ack_q   <= 1'b1;
                  end
                  rden_q  <= 1'b0;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               owner_q <= OWN_NONE;
               state_q <= S_IDLE;
            end
            default: begin
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               rden_q  <= 1'b0;
               owner_q <= OWN_NONE;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign I_ACK    = i_ack_q;
   assign I_RDATA  = i_rdata_q;
   assign D_ACK    = d_ack_q;
   assign D_RDATA  = d_rdata_q;
   assign DN_RDEN  = rden_q;
   assign DN_RADDR = raddr_q;
   assign OWNER    = owner_q;

endmodule
